// File: rtl/modport_blk_if.sv
// -----------------------------------------------------------------------------
// modport_blk_if -- packet-in / byte-out bus bundle for modport_blk.
//
// Signals
//   data_in   : packet byte stream (header, payload, parity)   master -> slave
//   pkt_valid : high for header/payload, low marks parity byte master -> slave
//   read_enb  : consumer read request                          master -> slave
//   busy      : write-side stall, data_in ignored while high   slave  -> master
//   error     : parity mismatch of the last completed packet   slave  -> master
//   data_out  : byte popped from the output FIFO               slave  -> master
//   vld_out   : output FIFO not empty                          slave  -> master
//
// The master modport is the traffic source/consumer side; the slave modport
// is the router block itself.
// -----------------------------------------------------------------------------
interface modport_blk_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             pkt_valid;
  logic             read_enb;
  logic             busy;
  logic             error;
  logic [WIDTH-1:0] data_out;
  logic             vld_out;

  modport master (
    output data_in, pkt_valid, read_enb,
    input  busy, error, data_out, vld_out
  );

  modport slave (
    input  data_in, pkt_valid, read_enb,
    output busy, error, data_out, vld_out
  );
endinterface

// File: rtl/modport_blk.sv
// -----------------------------------------------------------------------------
// modport_blk -- single-channel packet loader with parity check and output FIFO.
//
// Packets arrive as header, 1..63 payload bytes and one parity byte; every
// byte (parity included) is stored in a DEPTH-byte FIFO that the consumer
// drains with read_enb. The XOR of header and payload is compared with the
// received parity byte and the result is reported on error.
//
// Ports
//   clk_i   : clock, all state changes on the rising edge
//   rst_i   : asynchronous active-high reset
//   bus     : modport_blk_if.slave (data_in, pkt_valid, read_enb in;
//             busy, error, data_out, vld_out out)
//
// Parameters
//   WIDTH        : byte width (default 8)
//   DEPTH        : FIFO depth in bytes, power of two (default 16)
//   SOFT_TIMEOUT : idle-read timeout in cycles (default 30)
//
// Build option
//   SOFT_RESET_EN : when defined, a FIFO that holds data with no read
//                   request for SOFT_TIMEOUT consecutive cycles is flushed.
//                   Undefined (default): data is held indefinitely.
//
// state          | meaning
// ---------------+--------------------------------------------------------
// S_IDLE         | waiting for a header byte
// S_WAIT_EMPTY   | header latched, waiting for the FIFO to drain
// S_LOAD_DATA    | accepting payload bytes, parity byte ends the packet
// S_FULL_HOLD    | FIFO full, one latched byte waiting for space
// S_CHECK_PARITY | compare received parity with the running XOR
// -----------------------------------------------------------------------------
module modport_blk #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 16,
  parameter int SOFT_TIMEOUT = 30
) (
  input logic          clk_i,
  input logic          rst_i,
  modport_blk_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_WAIT_EMPTY   = 3'd1,
    S_LOAD_DATA    = 3'd2,
    S_FULL_HOLD    = 3'd3,
    S_CHECK_PARITY = 3'd4
  } state_t;

  state_t state_q, state_d;

  // FIFO storage and bookkeeping
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] data_out_q;
  logic             fifo_empty, fifo_full;
  logic             pop, can_write, flush;

  // packet datapath registers
  logic [WIDTH-1:0] hold_q;
  logic             hold_par_q;
  logic [WIDTH-1:0] par_q;
  logic [WIDTH-1:0] rx_par_q;
  logic             error_q;

  // FSM outputs
  logic             busy;
  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             hold_ld, hold_par_d;
  logic             par_init, par_acc, rx_ld;
  logic             err_clr, err_upd;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(DEPTH));
  assign pop        = bus.read_enb && !fifo_empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts a write.
  assign can_write  = !fifo_full || pop;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.pkt_valid) begin
          state_d = fifo_empty ? S_LOAD_DATA : S_WAIT_EMPTY;
        end
      end
      S_WAIT_EMPTY: begin
        if (fifo_empty) begin
          state_d = S_LOAD_DATA;
        end
      end
      S_LOAD_DATA: begin
        if (!can_write) begin
          state_d = S_FULL_HOLD;
        end else if (!bus.pkt_valid) begin
          state_d = S_CHECK_PARITY;
        end
      end
      S_FULL_HOLD: begin
        if (can_write) begin
          state_d = hold_par_q ? S_CHECK_PARITY : S_LOAD_DATA;
        end
      end
      S_CHECK_PARITY: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and datapath controls
  // ---------------------------------------------------------------------------
  always_comb begin
    busy       = 1'b0;
    push       = 1'b0;
    push_data  = bus.data_in;
    hold_ld    = 1'b0;
    hold_par_d = 1'b0;
    par_init   = 1'b0;
    par_acc    = 1'b0;
    rx_ld      = 1'b0;
    err_clr    = 1'b0;
    err_upd    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.pkt_valid) begin
          err_clr  = 1'b1;
          par_init = 1'b1;
          if (fifo_empty) begin
            push = 1'b1;
          end else begin
            hold_ld = 1'b1;
          end
        end
      end
      S_WAIT_EMPTY: begin
        busy = 1'b1;
        if (fifo_empty) begin
          push      = 1'b1;
          push_data = hold_q;
        end
      end
      S_LOAD_DATA: begin
        // The byte is sampled here whether or not it can be stored now;
        // a byte that finds the FIFO full waits in hold_q.
        if (bus.pkt_valid) begin
          par_acc = 1'b1;
        end else begin
          rx_ld      = 1'b1;
          hold_par_d = 1'b1;
        end
        if (can_write) begin
          push = 1'b1;
        end else begin
          hold_ld = 1'b1;
        end
      end
      S_FULL_HOLD: begin
        busy = 1'b1;
        if (can_write) begin
          push      = 1'b1;
          push_data = hold_q;
        end
      end
      S_CHECK_PARITY: begin
        busy    = 1'b1;
        err_upd = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Packet datapath: holding byte, running parity, error flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_q     <= '0;
      hold_par_q <= 1'b0;
      par_q      <= '0;
      rx_par_q   <= '0;
      error_q    <= 1'b0;
    end else begin
      if (hold_ld) begin
        hold_q     <= bus.data_in;
        hold_par_q <= hold_par_d;
      end
      if (par_init) begin
        par_q <= bus.data_in;
      end else if (par_acc) begin
        par_q <= par_q ^ bus.data_in;
      end
      if (rx_ld) begin
        rx_par_q <= bus.data_in;
      end
      if (err_clr) begin
        error_q <= 1'b0;
      end else if (err_upd) begin
        error_q <= (rx_par_q != par_q);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  assign wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      if (pop) begin
        data_out_q <= mem_q[rd_ptr_q];
      end
      if (flush) begin
        // Everything stored, including a byte written this cycle, is dropped.
        rd_ptr_q <= wr_ptr_d;
        count_q  <= '0;
      end else begin
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + AW'(1);
        end
        case ({push, pop})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Idle-read timeout
  // ---------------------------------------------------------------------------
`ifdef SOFT_RESET_EN
  localparam int TW = (SOFT_TIMEOUT > 1) ? $clog2(SOFT_TIMEOUT) : 1;

  logic [TW-1:0] idle_cnt_q;
  logic          idle_cond;

  assign idle_cond = !fifo_empty && !bus.read_enb;
  // Down-counter reaches zero on the SOFT_TIMEOUT-th consecutive idle cycle.
  assign flush     = idle_cond && (idle_cnt_q == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idle_cnt_q <= TW'(SOFT_TIMEOUT - 1);
    end else if (!idle_cond || flush) begin
      idle_cnt_q <= TW'(SOFT_TIMEOUT - 1);
    end else begin
      idle_cnt_q <= idle_cnt_q - TW'(1);
    end
  end
`else
  logic unused_timeout_cfg;

  assign flush              = 1'b0;
  assign unused_timeout_cfg = (SOFT_TIMEOUT > 0);
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.busy     = busy;
  assign bus.error    = error_q;
  assign bus.data_out = data_out_q;
  assign bus.vld_out  = !fifo_empty;

endmodule

// File: tb/tb_modport_blk.sv
module tb_modport_blk;

  logic clk;
  logic rst;

  modport_blk_if #(.WIDTH(8)) bus ();

  modport_blk #(
    .WIDTH       (8),
    .DEPTH       (16),
    .SOFT_TIMEOUT(30)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       pv;
    logic [7:0] din;
    logic       re;
    logic       busy;
    logic       vld;
    logic [7:0] dout;
    logic       err;
  } vec_t;

  vec_t       vt [28];
  logic [7:0] exp_q [$];
  logic [7:0] pkt [22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Waits for busy low, then presents one byte for the next rising edge.
  task automatic send_byte(input logic [7:0] b, input logic v);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.busy) begin
      errors++;
      $display("FAIL send_stall actual=busy required=not_busy");
    end
    bus.data_in   = b;
    bus.pkt_valid = v;
  endtask

  // Reads with read_enb held high and compares each popped byte against exp_q.
  task automatic drain(input int budget, input string tag);
    int         cyc;
    logic       was_vld;
    logic [7:0] e;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < budget) begin
      @(negedge clk);
      was_vld      = bus.vld_out;
      bus.read_enb = 1'b1;
      @(posedge clk);
      #1;
      if (was_vld) begin
        e = exp_q.pop_front();
        chk(tag, bus.data_out, e);
      end
      cyc++;
    end
    @(negedge clk);
    bus.read_enb = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout actual=%0d_left required=0_left", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] par;

    //                pv    din    re    busy  vld   dout   err
    vt[0]  = '{1'b1, 8'h0C, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0};
    vt[1]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0};
    vt[2]  = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 8'h0C, 1'b0};
    vt[3]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0};
    vt[4]  = '{1'b0, 8'h0C, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0};
    vt[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22, 1'b0};
    vt[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0};
    vt[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h0C, 1'b0};
    vt[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h0C, 1'b0};
    vt[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h0C, 1'b0};
    vt[10] = '{1'b1, 8'h0C, 1'b0, 1'b0, 1'b1, 8'h0C, 1'b0};
    vt[11] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'h0C, 1'b0};
    vt[12] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h0C, 1'b0};
    vt[13] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h0C, 1'b0};
    vt[14] = '{1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 8'h0C, 1'b0};
    vt[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h0C, 1'b1};
    vt[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h0C, 1'b1};
    vt[17] = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 8'h0C, 1'b0};
    vt[18] = '{1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0};
    vt[19] = '{1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0};
    vt[20] = '{1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 8'h33, 1'b0};
    vt[21] = '{1'b1, 8'h04, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0};
    vt[22] = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0};
    vt[23] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0};
    vt[24] = '{1'b0, 8'h51, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0};
    vt[25] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h04, 1'b0};
    vt[26] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0};
    vt[27] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h51, 1'b0};

    rst           = 1'b1;
    bus.data_in   = '0;
    bus.pkt_valid = 1'b0;
    bus.read_enb  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", bus.busy, 0);
    chk("reset_vld", bus.vld_out, 0);
    chk("reset_err", bus.error, 0);
    chk("reset_dout", bus.data_out, 0);

    // Cycle-accurate vectors: good packet, bad-parity packet, header while busy.
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      bus.pkt_valid = vt[i].pv;
      bus.data_in   = vt[i].din;
      bus.read_enb  = vt[i].re;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_busy", i), bus.busy, vt[i].busy);
      chk($sformatf("vec%0d_vld", i), bus.vld_out, vt[i].vld);
      chk($sformatf("vec%0d_dout", i), bus.data_out, vt[i].dout);
      chk($sformatf("vec%0d_err", i), bus.error, vt[i].err);
    end
    @(negedge clk);
    bus.pkt_valid = 1'b0;
    bus.read_enb  = 1'b0;

    // 20-byte payload with no reads: FIFO fills, stalls, then drains intact.
    pkt[0] = 8'h52;
    par    = pkt[0];
    for (int i = 1; i <= 20; i++) begin
      pkt[i] = 8'h80 + 8'(i - 1);
      par    = par ^ pkt[i];
    end
    pkt[21] = par;
    for (int i = 0; i < 22; i++) exp_q.push_back(pkt[i]);
    for (int i = 0; i < 17; i++) send_byte(pkt[i], 1'b1);
    @(negedge clk);
    chk("full_busy", bus.busy, 1);
    chk("full_vld", bus.vld_out, 1);
    repeat (5) @(negedge clk);
    chk("full_hold_busy", bus.busy, 1);
    fork
      begin
        for (int i = 17; i < 22; i++) send_byte(pkt[i], (i < 21));
      end
      drain(400, "full_data");
    join
    repeat (3) @(negedge clk);
    chk("full_end_vld", bus.vld_out, 0);
    chk("full_end_err", bus.error, 0);
    chk("full_end_busy", bus.busy, 0);

    // Bad packet leaves error set; async reset clears everything at once.
    send_byte(8'h04, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'h00, 1'b0);
    repeat (2) @(negedge clk);
    chk("bad_err_set", bus.error, 1);
    chk("bad_vld", bus.vld_out, 1);
    #2;
    rst           = 1'b1;
    bus.pkt_valid = 1'b0;
    #1;
    chk("arst_vld", bus.vld_out, 0);
    chk("arst_err", bus.error, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_dout", bus.data_out, 0);
    @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of a payload discards the partial packet.
    send_byte(8'h0C, 1'b1);
    send_byte(8'h11, 1'b1);
    @(negedge clk);
    #2;
    rst           = 1'b1;
    bus.pkt_valid = 1'b0;
    #1;
    chk("mid_rst_vld", bus.vld_out, 0);
    chk("mid_rst_busy", bus.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h08, 1'b1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h5A, 1'b1);
    send_byte(8'hF7, 1'b0);
    exp_q.push_back(8'h08);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hF7);
    drain(100, "post_rst_data");
    @(negedge clk);
    chk("post_rst_err", bus.error, 0);
    chk("post_rst_vld", bus.vld_out, 0);

    // Idle-read timeout behaviour.
    send_byte(8'h0C, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h0C, 1'b0);
    repeat (40) @(negedge clk);
`ifdef SOFT_RESET_EN
    chk("timeout_vld", bus.vld_out, 0);
    chk("timeout_err", bus.error, 0);
`else
    chk("timeout_vld", bus.vld_out, 1);
    chk("timeout_err", bus.error, 0);
    exp_q.push_back(8'h0C);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h0C);
    drain(100, "timeout_data");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
